rv32_wb_bridge: RTL

RV32_WB_BRIDGE -- requirements
Module: rv32_wb_bridge

---
 rtl/rv32_wb_pkg.sv | 21 ++
 rtl/rv32_wb_addr_decoder.sv | 33 +++
 rtl/rv32_wb_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: shared types and defaults for the RV32 to Wishbone bridge.
// Optional bus timeout is enabled by defining RV32_WB_TIMEOUT_EN.
package rv32_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } wb_state_e;

  localparam int          WB_N_SLAVES_DEF  = 4;
  localparam int          WB_ADR_W_DEF     = 16;
  localparam logic [31:0] WB_MMIO_BASE_DEF = 32'h4000_0000;
  localparam int          WB_TIMEOUT_DEF   = 255;
  localparam logic [31:0] WB_ERR_DATA      = 32'h0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32_wb_addr_decoder.sv
// rv32_wb_addr_decoder: maps a CPU byte address onto a slave window.
// Purely combinational; hit is low outside the MMIO region.
module rv32_wb_addr_decoder
  import rv32_wb_pkg::*;
#(
  parameter int          N_SLAVES  = WB_N_SLAVES_DEF,
  parameter int          ADR_W     = WB_ADR_W_DEF,
  parameter logic [31:0] MMIO_BASE = WB_MMIO_BASE_DEF,
  localparam int         IW        = idx_w(N_SLAVES)
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [IW-1:0] index
);

  // 33-bit bounds so a region ending at 4 GiB does not wrap
  localparam logic [32:0] BASE  = {1'b0, MMIO_BASE};
  localparam logic [32:0] LIMIT =
    BASE + (33'(N_SLAVES) << ADR_W);

  logic [32:0] addr_x;

  assign addr_x = {1'b0, addr};
  assign hit    = (addr_x >= BASE) &&
                  (addr_x < LIMIT);

  if (N_SLAVES > 1) begin : g_multi
    assign index = addr[ADR_W +: IW];
  end else begin : g_single
    assign index = '0;
  end

endmodule

// File: rtl/rv32_wb_bridge.sv
// rv32_wb_bridge: single-outstanding CPU to N-slave Wishbone bridge.
// Define RV32_WB_TIMEOUT_EN to abort bus cycles after TIMEOUT_CYCLES.
module rv32_wb_bridge
  import rv32_wb_pkg::*;
#(
  parameter int          N_SLAVES       = WB_N_SLAVES_DEF,
  parameter int          ADR_W          = WB_ADR_W_DEF,
  parameter logic [31:0] MMIO_BASE      = WB_MMIO_BASE_DEF,
  parameter int          TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  input  logic [3:0]            mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_data_i,
  output logic [31:0]           mem_data_o,
  output logic                  mem_ready_o,
  output logic                  mem_err_o,
  output logic [N_SLAVES-1:0]   wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADR_W-1:0]      wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [N_SLAVES-1:0]   wb_ack_i,
  input  logic [N_SLAVES*32-1:0] wb_dat_i
);

  localparam int IW = idx_w(N_SLAVES);

  if (N_SLAVES < 1 || N_SLAVES > 16 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rv32_wb_bridge: bad parameters");
  end

  wb_state_e     state_q;
  wb_state_e     state_d;
  logic          hit;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_q;
  logic          ack_sel;
  logic [31:0]   rdat_sel;
  logic          start;
  logic          done_ok;
  logic          done_err;
  logic          tmo;

  rv32_wb_addr_decoder #(
    .N_SLAVES  (N_SLAVES),
    .ADR_W     (ADR_W),
    .MMIO_BASE (MMIO_BASE)
  ) u_dec (
    .addr  (mem_addr_i),
    .hit   (hit),
    .index (idx)
  );

  assign ack_sel  = wb_ack_i[idx_q];
  assign rdat_sel = wb_dat_i[32*idx_q +: 32];

`ifdef RV32_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = (state_q == ST_BUS) &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (state_q == ST_BUS &&
                 !ack_sel && !tmo) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (hit) begin
            state_d = ST_BUS;
            start   = 1'b1;
          end else begin
            state_d  = ST_RESP;
            done_err = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (ack_sel) begin
          state_d = ST_RESP;
          done_ok = 1'b1;
        end else if (tmo) begin
          state_d  = ST_RESP;
          done_err = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cyc/stb follow the state register so reset clears them at once
  always_comb begin
    wb_cyc_o = '0;
    if (state_q == ST_BUS) begin
      wb_cyc_o[idx_q] = 1'b1;
    end
  end

  assign wb_stb_o = (state_q == ST_BUS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      wb_adr_o    <= '0;
      wb_dat_o    <= 32'h0;
      mem_data_o  <= 32'h0;
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
    end else begin
      mem_ready_o <= done_ok | done_err;
      mem_err_o   <= done_err;
      if (start) begin
        idx_q    <= idx;
        wb_adr_o <= mem_addr_i[ADR_W-1:0];
        wb_dat_o <= mem_data_i;
        wb_we_o  <= (mem_we_i != 4'h0);
        wb_sel_o <= (mem_we_i != 4'h0) ?
                    mem_we_i : 4'hF;
      end
      if (done_ok) begin
        mem_data_o <= wb_we_o ? 32'h0 : rdat_sel;
      end else if (done_err) begin
        mem_data_o <= WB_ERR_DATA;
      end
    end
  end

endmodule
